// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - opcodes, header layout, FSM states and param-count helper for cmd_packet_decoder
package raster_pkg;

    localparam logic [2:0] OP_CLEAR     = 3'd0;
    localparam logic [2:0] OP_PIXEL     = 3'd1;
    localparam logic [2:0] OP_LINE      = 3'd2;
    localparam logic [2:0] OP_RECT      = 3'd3;
    localparam logic [2:0] OP_FILL      = 3'd4;
    localparam logic [2:0] OP_SET_COLOR = 3'd5;

    localparam int HDR_START_BIT = 7;
    localparam int HDR_OP_MSB    = 6;
    localparam int HDR_OP_LSB    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARAM = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_SET_COLOR;
    endfunction

    function automatic logic [1:0] param_bytes(input logic [2:0] op);
        case (op)
            OP_PIXEL, OP_SET_COLOR:    return 2'd1;
            OP_LINE, OP_RECT, OP_FILL: return 2'd2;
            default:                   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_packet_decoder_if.sv
// rtl/cmd_packet_decoder_if.sv - byte input stream and decoded command output bundle
interface cmd_packet_decoder_if #(
    parameter int COORD_W = 3,
    parameter int COLOR_W = 4
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;

    logic [2:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic [COORD_W-1:0] cmd_x2;
    logic [COORD_W-1:0] cmd_y2;
    logic [COLOR_W-1:0] cmd_color;
    logic               cmd_valid;
    logic               cmd_ready;

    // slave: the decoder; master: host byte source plus draw engine
    modport slave (
        input  in_data, in_valid, cmd_ready,
        output in_ready, cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color, cmd_valid
    );

    modport master (
        output in_data, in_valid, cmd_ready,
        input  in_ready, cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color, cmd_valid
    );
endinterface

// File: rtl/cmd_watchdog.sv
// rtl/cmd_watchdog.sv - mid-packet idle counter, pulses o_expire after TIMEOUT_CYCLES idle cycles
module cmd_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_kick,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en && !i_kick && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_kick || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/cmd_packet_decoder.sv
// rtl/cmd_packet_decoder.sv - assembles header+param byte packets into range-checked draw commands
// Optional mid-packet timeout enabled by defining CMD_DECODER_TIMEOUT_EN.
module cmd_packet_decoder
    import raster_pkg::*;
#(
    parameter int COORD_W        = 3,
    parameter int COLOR_W        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmd_packet_decoder_if.slave  bus,
    output logic                 busy,
    output logic                 err_illegal,
    output logic                 err_range,
    output logic                 err_timeout
);
    localparam logic [3:0] COORD_MAX = 4'((1 << COORD_W) - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op;
    logic [1:0]         r_cnt;
    logic [COORD_W-1:0] r_p0_hi;
    logic [COORD_W-1:0] r_p0_lo;
    logic [2:0]         r_cmd_op;
    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic [COORD_W-1:0] r_x2;
    logic [COORD_W-1:0] r_y2;
    logic [COLOR_W-1:0] r_color;
    logic               r_err_illegal;
    logic               r_err_range;

    logic       w_in_fire;
    logic       w_hdr_start;
    logic [2:0] w_hdr_op;
    logic [3:0] w_hi;
    logic [3:0] w_lo;
    logic       w_last;
    logic       w_coord_bad;
    logic       w_size_bad;
    logic       w_range_err;
    logic       w_wd_expire;
    logic       w_load_hdr;
    logic       w_save_p0;
    logic       w_commit;
    logic       w_commit_clear;
    logic       w_set_illegal;
    logic       w_set_range;

    assign w_in_fire   = bus.in_valid && bus.in_ready;
    assign w_hdr_start = bus.in_data[HDR_START_BIT];
    assign w_hdr_op    = bus.in_data[HDR_OP_MSB:HDR_OP_LSB];
    assign w_hi        = bus.in_data[7:4];
    assign w_lo        = bus.in_data[3:0];
    assign w_last      = (r_cnt == 2'd1);

    // Colour bytes are never range-checked; width/height only exist on the last RECT/FILL byte
    assign w_coord_bad = (w_hi > COORD_MAX) || (w_lo > COORD_MAX);
    assign w_size_bad  = ((r_op == OP_RECT) || (r_op == OP_FILL)) && w_last &&
                         ((w_hi == 4'd0) || (w_lo == 4'd0));
    assign w_range_err = (r_op != OP_SET_COLOR) && (w_coord_bad || w_size_bad);

`ifdef CMD_DECODER_TIMEOUT_EN
    logic r_err_timeout;

    cmd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (r_state == ST_PARAM),
        .i_kick   (w_in_fire),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_wd_expire;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_hdr     = 1'b0;
        w_save_p0      = 1'b0;
        w_commit       = 1'b0;
        w_commit_clear = 1'b0;
        w_set_illegal  = 1'b0;
        w_set_range    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire && w_hdr_start) begin
                    if (!op_is_legal(w_hdr_op)) begin
                        w_set_illegal = 1'b1;
                    end else if (param_bytes(w_hdr_op) == 2'd0) begin
                        w_load_hdr     = 1'b1;
                        w_commit_clear = 1'b1;
                        w_state_nxt    = ST_ISSUE;
                    end else begin
                        w_load_hdr  = 1'b1;
                        w_state_nxt = ST_PARAM;
                    end
                end
            end
            ST_PARAM: begin
                if (w_in_fire) begin
                    if (w_range_err) begin
                        w_set_range = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_last) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_save_p0 = 1'b1;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= OP_CLEAR;
            r_cnt         <= 2'd0;
            r_p0_hi       <= '0;
            r_p0_lo       <= '0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            r_err_illegal <= w_set_illegal;
            r_err_range   <= w_set_range;
            if (w_load_hdr) begin
                r_op  <= w_hdr_op;
                r_cnt <= param_bytes(w_hdr_op);
            end else if (w_save_p0) begin
                r_cnt   <= r_cnt - 2'd1;
                r_p0_hi <= w_hi[COORD_W-1:0];
                r_p0_lo <= w_lo[COORD_W-1:0];
            end
        end
    end

    // Output fields only change on a clean packet, so dropped packets leave them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_op <= OP_CLEAR;
            r_x1     <= '0;
            r_y1     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
            r_color  <= '0;
        end else if (w_commit_clear) begin
            r_cmd_op <= OP_CLEAR;
        end else if (w_commit) begin
            r_cmd_op <= r_op;
            case (r_op)
                OP_PIXEL: begin
                    r_x1 <= w_hi[COORD_W-1:0];
                    r_y1 <= w_lo[COORD_W-1:0];
                end
                OP_SET_COLOR: begin
                    r_color <= bus.in_data[COLOR_W-1:0];
                end
                default: begin
                    r_x1 <= r_p0_hi;
                    r_y1 <= r_p0_lo;
                    r_x2 <= w_hi[COORD_W-1:0];
                    r_y2 <= w_lo[COORD_W-1:0];
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state != ST_ISSUE);
    assign bus.cmd_valid = (r_state == ST_ISSUE);
    assign bus.cmd_op    = r_cmd_op;
    assign bus.cmd_x1    = r_x1;
    assign bus.cmd_y1    = r_y1;
    assign bus.cmd_x2    = r_x2;
    assign bus.cmd_y2    = r_y2;
    assign bus.cmd_color = r_color;
    assign busy          = (r_state != ST_IDLE);
    assign err_illegal   = r_err_illegal;
    assign err_range     = r_err_range;
endmodule

// File: tb/tb_cmd_packet_decoder.sv
// tb/tb_cmd_packet_decoder.sv - directed and randomized self-checking bench for cmd_packet_decoder
`timescale 1ns/1ps
module tb_cmd_packet_decoder;
    localparam int COORD_W        = 3;
    localparam int COLOR_W        = 4;
    localparam int TIMEOUT_CYCLES = 4;
    localparam int CMAX           = (1 << COORD_W) - 1;

    typedef struct packed {
        logic [2:0]         op;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COLOR_W-1:0] color;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, err_illegal, err_range, err_timeout;

    cmd_packet_decoder_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) bif();

    cmd_packet_decoder #(
        .COORD_W(COORD_W), .COLOR_W(COLOR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .busy(busy),
        .err_illegal(err_illegal), .err_range(err_range), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   n_ill = 0, n_rng = 0, n_tmo = 0;
    bit   rdy_rand = 1'b0;
    bit   prev_stall = 1'b0;
    cmd_t prev_cmd;
    cmd_t obs_q[$];
    cmd_t exp_q[$];

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.op = bif.cmd_op; c.x1 = bif.cmd_x1; c.y1 = bif.cmd_y1;
        c.x2 = bif.cmd_x2; c.y2 = bif.cmd_y2; c.color = bif.cmd_color;
        return c;
    endfunction

    function automatic cmd_t mk(input int op, x1, y1, x2, y2, color);
        cmd_t c;
        c.op = 3'(op); c.x1 = COORD_W'(x1); c.y1 = COORD_W'(y1);
        c.x2 = COORD_W'(x2); c.y2 = COORD_W'(y2); c.color = COLOR_W'(color);
        return c;
    endfunction

    // Monitor: samples 1ns after the falling edge, records handshakes and error pulses
    always begin
        @(negedge clk);
        #1;
        if (rdy_rand) bif.cmd_ready = 1'($urandom_range(0, 1));
        if (err_illegal) n_ill++;
        if (err_range)   n_rng++;
        if (err_timeout) n_tmo++;
        if (bif.cmd_valid) begin
            if (prev_stall) begin
                checks++;
                if (cur_cmd() !== prev_cmd) begin
                    failures++;
                    $display("FAIL stall_hold got=%h exp=%h", cur_cmd(), prev_cmd);
                end
            end
            if (bif.cmd_ready) obs_q.push_back(cur_cmd());
            prev_stall = !bif.cmd_ready;
            prev_cmd   = cur_cmd();
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_q.delete(); n_ill = 0; n_rng = 0; n_tmo = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bif.in_data  = b;
        bif.in_valid = 1'b1;
        while (bif.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL send_handshake byte=%h in_ready=%b exp=1", b, bif.in_ready);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_obs();
    endtask

    task automatic test_reset();
        logic [5:0] st;
        st = {busy, bif.in_ready, bif.cmd_valid, err_illegal, err_range, err_timeout};
        checks++;
        if (st !== 6'b010000 || cur_cmd() !== '0) begin
            failures++;
            $display("FAIL reset_state st=%b cmd=%h exp st=010000 cmd=0", st, cur_cmd());
        end
        rst_n = 1'b1;
        idle(2);
        st = {busy, bif.in_ready, bif.cmd_valid, err_illegal, err_range, err_timeout};
        checks++;
        if (st !== 6'b010000) begin
            failures++;
            $display("FAIL post_reset st=%b exp=010000", st);
        end
    endtask

    task automatic test_pixel();
        clear_obs();
        bif.cmd_ready = 1'b1;
        send_byte(8'h90);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL pixel_busy got=%b exp=1", busy);
        end
        send_byte(8'h35);
        checks++;
        if (bif.cmd_valid !== 1'b1 || cur_cmd() !== mk(1, 3, 5, 0, 0, 0)) begin
            failures++;
            $display("FAIL pixel_cmd valid=%b cmd=%h exp valid=1 cmd=%h", bif.cmd_valid, cur_cmd(), mk(1, 3, 5, 0, 0, 0));
        end
        checks++;
        if ({err_illegal, err_range, err_timeout} !== 3'b000) begin
            failures++; $display("FAIL pixel_err got=%b exp=000", {err_illegal, err_range, err_timeout});
        end
        idle(1);
        checks++;
        if (bif.cmd_valid !== 1'b0 || busy !== 1'b0 || obs_q.size() != 1) begin
            failures++;
            $display("FAIL pixel_release valid=%b busy=%b n=%0d exp 0 0 1", bif.cmd_valid, busy, obs_q.size());
        end
    endtask

    task automatic test_line_stall();
        clear_obs();
        bif.cmd_ready = 1'b0;
        send_byte(8'hA0);
        send_byte(8'h12);
        send_byte(8'h76);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bif.cmd_valid !== 1'b1 || bif.in_ready !== 1'b0 || cur_cmd() !== mk(2, 1, 2, 7, 6, 0)) begin
                failures++;
                $display("FAIL line_stall cyc=%0d valid=%b in_ready=%b cmd=%h exp 1 0 %h",
                         i, bif.cmd_valid, bif.in_ready, cur_cmd(), mk(2, 1, 2, 7, 6, 0));
            end
            idle(1);
        end
        bif.cmd_ready = 1'b1;
        idle(1);
        checks++;
        if (bif.cmd_valid !== 1'b0 || obs_q.size() != 1) begin
            failures++; $display("FAIL line_release valid=%b n=%0d exp 0 1", bif.cmd_valid, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== mk(2, 1, 2, 7, 6, 0)) begin
                failures++; $display("FAIL line_cmd got=%h exp=%h", obs_q[0], mk(2, 1, 2, 7, 6, 0));
            end
        end
    endtask

    task automatic test_range();
        clear_obs();
        bif.cmd_ready = 1'b1;
        send_byte(8'hB0);
        send_byte(8'h00);
        send_byte(8'h80);
        checks++;
        if (err_range !== 1'b1 || bif.cmd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL range_coord err=%b valid=%b busy=%b exp 1 0 0", err_range, bif.cmd_valid, busy);
        end
        idle(1);
        checks++;
        if (err_range !== 1'b0) begin
            failures++; $display("FAIL range_pulse_width err=%b exp=0", err_range);
        end
        send_byte(8'hB0);
        send_byte(8'h11);
        send_byte(8'h03);
        checks++;
        if (err_range !== 1'b1 || bif.cmd_valid !== 1'b0) begin
            failures++; $display("FAIL range_zero_w err=%b valid=%b exp 1 0", err_range, bif.cmd_valid);
        end
        idle(2);
        checks++;
        if (n_rng != 2 || obs_q.size() != 0) begin
            failures++; $display("FAIL range_count rng=%0d cmds=%0d exp 2 0", n_rng, obs_q.size());
        end
    endtask

    task automatic test_illegal();
        clear_obs();
        send_byte(8'hE0);
        checks++;
        if (err_illegal !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL illegal err=%b busy=%b exp 1 0", err_illegal, busy);
        end
        send_byte(8'h12);
        send_byte(8'h7F);
        idle(2);
        checks++;
        if (n_ill != 1 || n_rng != 0 || busy !== 1'b0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL discard ill=%0d rng=%0d busy=%b cmds=%0d exp 1 0 0 0", n_ill, n_rng, busy, obs_q.size());
        end
    endtask

    task automatic test_clear_color();
        clear_obs();
        bif.cmd_ready = 1'b1;
        send_byte(8'h80);
        checks++;
        if (bif.cmd_valid !== 1'b1 || bif.in_ready !== 1'b0 || bif.cmd_op !== 3'd0) begin
            failures++;
            $display("FAIL clear_issue valid=%b in_ready=%b op=%0d exp 1 0 0", bif.cmd_valid, bif.in_ready, bif.cmd_op);
        end
        send_byte(8'hD0);
        send_byte(8'h0A);
        idle(2);
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL clear_color_count got=%0d exp=2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].op !== 3'd0 || obs_q[1].op !== 3'd5 || obs_q[1].color !== 4'hA) begin
                failures++;
                $display("FAIL clear_color_seq op0=%0d op1=%0d color=%h exp 0 5 a", obs_q[0].op, obs_q[1].op, obs_q[1].color);
            end
        end
    endtask

`ifdef CMD_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        clear_obs();
        bif.cmd_ready = 1'b1;
        send_byte(8'hA0);
        send_byte(8'h12);
        idle(3);
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_early busy=%b tmo=%b exp 1 0", busy, err_timeout);
        end
        idle(1);
        checks++;
        if (busy !== 1'b0 || err_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_fire busy=%b tmo=%b exp 0 1", busy, err_timeout);
        end
        send_byte(8'h34);
        idle(2);
        checks++;
        if (obs_q.size() != 0 || n_tmo != 1) begin
            failures++; $display("FAIL timeout_drop cmds=%0d tmo=%0d exp 0 1", obs_q.size(), n_tmo);
        end
    endtask
`else
    task automatic test_timeout();
        clear_obs();
        bif.cmd_ready = 1'b1;
        send_byte(8'hA0);
        send_byte(8'h12);
        idle(20);
        checks++;
        if (busy !== 1'b1 || n_tmo != 0) begin
            failures++; $display("FAIL param_wait busy=%b tmo=%0d exp 1 0", busy, n_tmo);
        end
        send_byte(8'h34);
        checks++;
        if (bif.cmd_valid !== 1'b1 || cur_cmd().x2 !== 3'd3 || cur_cmd().y2 !== 3'd4) begin
            failures++;
            $display("FAIL param_wait_done valid=%b cmd=%h exp valid=1 x2=3 y2=4", bif.cmd_valid, cur_cmd());
        end
        idle(2);
    endtask
`endif

    task automatic test_reset_mid();
        clear_obs();
        bif.cmd_ready = 1'b1;
        send_byte(8'hA0);
        send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bif.in_ready !== 1'b1 || bif.cmd_valid !== 1'b0 || cur_cmd() !== '0) begin
            failures++;
            $display("FAIL reset_mid busy=%b in_ready=%b valid=%b cmd=%h exp 0 1 0 0",
                     busy, bif.in_ready, bif.cmd_valid, cur_cmd());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h34);
        send_byte(8'h90);
        send_byte(8'h35);
        idle(2);
        checks++;
        if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== mk(1, 3, 5, 0, 0, 0))) begin
            failures++; $display("FAIL reset_mid_after cmds=%0d exp 1 pixel(3,5)", obs_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] b, p;
        logic [2:0] op;
        int   k, got, i, e_ill, e_rng, n;
        bit   ok;
        cmd_t cur, nxt;
        logic [7:0] prm[2];

        do_reset();
        exp_q.delete();
        for (int pk = 0; pk < 60; pk++) begin
            if ($urandom_range(0, 9) == 0) begin
                s.push_back({1'b0, 7'($urandom)});
            end else begin
                op = 3'($urandom_range(0, 7));
                s.push_back({1'b1, op, 4'($urandom)});
                k = (op == 3'd1 || op == 3'd5) ? 1 : ((op >= 3'd2 && op <= 3'd4) ? 2 : 0);
                for (int j = 0; j < k; j++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        s.push_back(8'($urandom));
                    end else if (j == 1) begin
                        s.push_back({4'($urandom_range(1, CMAX)), 4'($urandom_range(1, CMAX))});
                    end else begin
                        s.push_back({4'($urandom_range(0, CMAX)), 4'($urandom_range(0, CMAX))});
                    end
                end
            end
        end
        s.push_back(8'h80); s.push_back(8'h80); s.push_back(8'h80);

        cur = '0; i = 0; e_ill = 0; e_rng = 0;
        while (i < s.size()) begin
            b = s[i]; i++;
            if (!b[7]) continue;
            op = b[6:4];
            if (op > 3'd5) begin e_ill++; continue; end
            k = (op == 3'd0) ? 0 : ((op == 3'd1 || op == 3'd5) ? 1 : 2);
            ok = 1'b1; got = 0;
            for (int j = 0; j < k && i < s.size(); j++) begin
                p = s[i]; i++; got++; prm[j] = p;
                if (op != 3'd5) begin
                    if (int'(p[7:4]) > CMAX || int'(p[3:0]) > CMAX) ok = 1'b0;
                    if ((op == 3'd3 || op == 3'd4) && j == 1 && (p[7:4] == 0 || p[3:0] == 0)) ok = 1'b0;
                end
                if (!ok) begin e_rng++; break; end
            end
            if (ok && got == k) begin
                nxt = cur; nxt.op = op;
                if (op == 3'd1) begin
                    nxt.x1 = COORD_W'(prm[0][7:4]); nxt.y1 = COORD_W'(prm[0][3:0]);
                end else if (op == 3'd5) begin
                    nxt.color = prm[0][COLOR_W-1:0];
                end else if (op != 3'd0) begin
                    nxt.x1 = COORD_W'(prm[0][7:4]); nxt.y1 = COORD_W'(prm[0][3:0]);
                    nxt.x2 = COORD_W'(prm[1][7:4]); nxt.y2 = COORD_W'(prm[1][3:0]);
                end
                exp_q.push_back(nxt);
                cur = nxt;
            end
        end

        rdy_rand = 1'b1;
        foreach (s[idx]) begin
            idle($urandom_range(0, 2));
            send_byte(s[idx]);
        end
        n = 0;
        while ((busy || obs_q.size() < exp_q.size()) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        idle(2);
        rdy_rand = 1'b0;
        bif.cmd_ready = 1'b0;

        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
            checks++;
            if (obs_q[j] !== exp_q[j]) begin
                failures++; $display("FAIL rand_cmd idx=%0d got=%h exp=%h", j, obs_q[j], exp_q[j]);
            end
        end
        checks++;
        if (n_ill != e_ill || n_rng != e_rng) begin
            failures++; $display("FAIL rand_errs ill=%0d rng=%0d exp %0d %0d", n_ill, n_rng, e_ill, e_rng);
        end
    endtask

    initial begin
        bif.in_data   = 8'h00;
        bif.in_valid  = 1'b0;
        bif.cmd_ready = 1'b0;
        idle(2);
        test_reset();
        test_pixel();
        test_line_stall();
        test_range();
        test_illegal();
        test_clear_color();
        test_timeout();
        test_reset_mid();
        test_random();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
